// File: rtl/buffer_pkg.sv
// ----------------------------------------------------------------------------
// buffer_pkg
//   Shared types and helpers for the tagged DTN input buffer.
//   - BUFFER_SLOT_T(AW, DW): slot record {reserved, filled, src, data} at any
//     address/data width. Packages cannot take parameters, so modules build
//     their own slot type through this macro.
//   - slot_t: the slot record at the default widths (4-bit src, 64-bit data).
//   - next_ptr(): ring-pointer increment that wraps depth-1 -> 0 by compare,
//     so non-power-of-two depths work.
// ----------------------------------------------------------------------------
`ifndef BUFFER_SLOT_T
`define BUFFER_SLOT_T(AW, DW) \
    struct packed { \
        logic          reserved; \
        logic          filled; \
        logic [AW-1:0] src; \
        logic [DW-1:0] data; \
    }
`endif

package buffer_pkg;

    typedef `BUFFER_SLOT_T(4, 64) slot_t;

    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/buffer_input_tagged_tag_match_arbiter.sv
// ----------------------------------------------------------------------------
// tag_match_arbiter
//   Picks the oldest matching slot, scanning the ring from head in age order.
//   Ports:
//     match_i  DEPTH   per-slot match candidates
//     head_i   PTR_W   index of the oldest slot
//     grant_o  DEPTH   one-hot of the oldest candidate (zero when none)
//     hit_o    1       at least one candidate exists
// ----------------------------------------------------------------------------
module tag_match_arbiter
    import buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match_i,
    input  logic [PTR_W-1:0] head_i,
    output logic [DEPTH-1:0] grant_o,
    output logic             hit_o
);

    logic [PTR_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise the tool infers a latch.
    always_comb begin
        grant_o = '0;
        hit_o   = 1'b0;
        idx     = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit_o && match_i[idx]) begin
                grant_o[idx] = 1'b1;
                hit_o        = 1'b1;
            end
            idx = PTR_W'(next_ptr(32'(idx), DEPTH));
        end
    end

endmodule

// File: rtl/buffer_input_tagged.sv
// ----------------------------------------------------------------------------
// buffer_input_tagged
//   Input buffer between the DTN and a PU operand port. The CU reserves slots
//   in order, tagging each with the source it expects; DTN messages fill the
//   oldest pending slot with a matching source, in any arrival order; the PU
//   drains strictly in reservation order.
//   Ports:
//     clock, rst_n           clock, synchronous active-low reset
//     cu_valid/cu_src        reserve one slot expecting cu_src
//     cu_ready               a slot is free (registered count != DEPTH)
//     dtn_valid/src/data     incoming message, never back-pressured
//     pu_valid/pu_data       head slot filled / its payload (0 when not valid)
//     pu_ready               PU consumes the head
//     flush                  discard all slots
//     count                  reserved slots
//     error                  sticky, set by an unmatched DTN message
// ----------------------------------------------------------------------------
module buffer_input_tagged
    import buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 5
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       cu_valid,
    input  logic [ADDR_WIDTH-1:0]      cu_src,
    output logic                       cu_ready,
    input  logic                       dtn_valid,
    input  logic [ADDR_WIDTH-1:0]      dtn_src,
    input  logic [DATA_WIDTH-1:0]      dtn_data,
    output logic                       pu_valid,
    output logic [DATA_WIDTH-1:0]      pu_data,
    input  logic                       pu_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       error
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

    typedef `BUFFER_SLOT_T(ADDR_WIDTH, DATA_WIDTH) buf_slot_t;

    buf_slot_t          slot_q [DEPTH];
    buf_slot_t          slot_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               error_q, error_d;

    logic               reserve;
    logic               pop;
    logic [DEPTH-1:0]   match;
    logic [DEPTH-1:0]   grant;
    logic               hit;

    // Outputs decode registered state only.
    assign cu_ready = (count_q != COUNT_W'(DEPTH));
    assign pu_valid = slot_q[head_q].filled;
    assign pu_data  = pu_valid ? slot_q[head_q].data : '0;
    assign count    = count_q;
    assign error    = error_q;

    assign reserve  = cu_valid && cu_ready;
    assign pop      = pu_valid && pu_ready;

    // Candidates: pending slots waiting on this source, plus the slot being
    // reserved this cycle. The tail is the youngest position in the ring, so
    // the age-ordered scan reaches it only after every older slot.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = slot_q[i].reserved && !slot_q[i].filled &&
                       (slot_q[i].src == dtn_src);
        end
        if (reserve && (cu_src == dtn_src)) begin
            match[tail_q] = 1'b1;
        end
        if (!dtn_valid || flush) begin
            match = '0;
        end
    end

    tag_match_arbiter #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_arbiter (
        .match_i (match),
        .head_i  (head_q),
        .grant_o (grant),
        .hit_o   (hit)
    );

    always_comb begin
        slot_d  = slot_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        error_d = error_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i].reserved = 1'b0;
                slot_d[i].filled   = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Reserve is written before fill so a same-cycle match on the
            // tail slot lands on top of the fresh reservation.
            if (reserve) begin
                slot_d[tail_q] = '{reserved: 1'b1, filled: 1'b0,
                                   src: cu_src, data: '0};
                tail_d = PTR_W'(next_ptr(32'(tail_q), DEPTH));
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[i]) begin
                    slot_d[i].filled = 1'b1;
                    slot_d[i].data   = dtn_data;
                end
            end
            if (dtn_valid && !hit) begin
                error_d = 1'b1;
            end
            // Pop only targets a slot filled in registered state, never the
            // slot filled this cycle, so it cannot collide with the fill.
            if (pop) begin
                slot_d[head_q] = '0;
                head_d = PTR_W'(next_ptr(32'(head_q), DEPTH));
            end
            case ({reserve, pop})
                2'b10:   count_d = count_q + COUNT_W'(1);
                2'b01:   count_d = count_q - COUNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            // NOTE: the slot array is reset, not left uninitialised: stale
            // reserved/filled bits would be matched or popped after reset.
            slot_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

endmodule

// File: doc/buffer_input_tagged.md
# buffer_input_tagged

Parametrised input buffer between the data transport network (DTN) and a processing-unit operand port. Replaces the fixed-depth input buffer: depth, address width and data width are parameters. Each slot records the expected source address, so messages from different sources can arrive in any order. Adds flush, occupancy output and a sticky error flag. Data is released to the PU strictly in control-unit (CU) reservation order.

## Interface
- ADDR_WIDTH, 4, DTN source-address width
- DATA_WIDTH, 64, operand width
- DEPTH, 5, slot count; any value ≥2, not restricted to powers of two
- clock  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- cu_valid  in  1  CU reserves one slot
- cu_src  in  ADDR_WIDTH  source address the reserved slot expects
- cu_ready  out  1  slot available
- dtn_valid  in  1  message present; nonblocking, never back-pressured
- dtn_src  in  ADDR_WIDTH  sender address
- dtn_data  in  DATA_WIDTH  payload
- pu_valid  out  1  head slot is filled
- pu_data  out  DATA_WIDTH  head slot payload
- pu_ready  in  1  PU consumes head
- flush  in  1  discard all slots
- count  out  $clog2(DEPTH+1)  occupied (reserved) slots
- error  out  1  sticky; set by an unmatched DTN message

## Operation
- Slot state: reserved, filled, src, data. Head and tail pointers wrap at DEPTH−1 → 0 by explicit compare, not bit truncation.
- Reserve: cu_valid && cu_ready writes src=cu_src, reserved=1 and filled=0 at tail, then advances tail.
- Fill: on dtn_valid, search from head in age order for the oldest slot with reserved && !filled && src==dtn_src. On a match, write data and set filled.
- Same-cycle match: the slot being reserved in the current cycle is also a match candidate, searched after all older slots. A message may therefore fill a reservation made in the same cycle.
- Unmatched message: dropped, error←1. error clears only on reset. A message from the same source is never matched to a younger slot while an older slot from that source is pending.
- Pop: pu_valid && pu_ready clears the head slot and advances head.
- count: tracks +reserve −pop. Reserve and pop in the same cycle leaves count unchanged.
- Flush: clears all reserved/filled bits and sets head=tail=0 and count=0 on the next edge. Flush has priority over a same-cycle reserve, fill or pop; those are discarded. A DTN message arriving during flush does not set error.
- Reset (rst_n=0 at an edge, including mid-operation): all slots cleared, head=tail=0, count=0, error=0. Outputs after reset: cu_ready=1, pu_valid=0, pu_data=0, count=0, error=0.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- cu_ready = (count != DEPTH), based on registered count. When full, a same-cycle pop does not allow a reserve; the reserve must wait one cycle.
- Fill at edge t makes pu_valid=1 visible from t+1, provided the filled slot is the head.
- Pop at edge t exposes the next head from t+1. Back-to-back pops at one per cycle are sustained when the slots are pre-filled.
- Minimum latency from a DTN message to PU availability is 1 cycle.
- Reserve, fill and pop may all occur in one cycle, including on the same slot when count=0 at reservation. Pop applies only to a slot already filled in registered state.

## Structure
- Shared package buffer_pkg holds:
  - typedef slot_t (reserved, filled, src, data), parametrised through a package-level parameterised struct or a macro as the package allows
  - function next_ptr(ptr, depth) for wrap-around
- One sub-module: tag_match_arbiter. Inputs are the per-slot match vector and head; output is one-hot of the oldest match plus a hit bit.

## Test plan
- Reserve src 3,5; DTN sends src5=0xBB then src3=0xAA → PU receives 0xAA then 0xBB, count 2→0, error 0.
- Reserve src 2 three times and send three src2 messages 1,2,3 → output order 1,2,3.
- DEPTH=5: reserve 5 → cu_ready=0, count=5. Pop while cu_valid=1 → no reserve that cycle; cu_ready=1 the next cycle. Run 12 reserve/pop rounds to cover the pointer wrap 4→0.
- Empty buffer: reserve src 7 and send a src7 message with data 0x11 in the same cycle → pu_valid=1 the next cycle with pu_data=0x11.
- Message from src 9 with no reservation → dropped, error=1, and error stays 1 after later valid traffic.
- Flush with 3 slots occupied and a concurrent DTN message → count=0, pu_valid=0, error unchanged. Repeat with rst_n=0 mid-operation → all outputs at reset values.
